// File: rtl/button_gesture.sv
// Groups debounced short/long press pulses into click/long gestures behind a one-entry valid/ready event buffer.
// Optional combined click+long gesture (code 3) enabled by defining BUTTON_GESTURE_COMBO_EN.
module button_gesture #(
    parameter int unsigned GAP_CYCLES = 3072,
    parameter int unsigned MAX_CLICKS = 3,
    parameter int unsigned CNT_W      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       press_short,
    input  logic       press_long,
    output logic       ev_valid,
    output logic [2:0] ev_code,
    output logic [2:0] ev_count,
    input  logic       ev_ready,
    output logic       overflow,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        COUNTING
    } state_t;

    localparam logic [2:0]       CODE_CLICK      = 3'd1;
    localparam logic [2:0]       CODE_LONG       = 3'd2;
`ifdef BUTTON_GESTURE_COMBO_EN
    localparam logic [2:0]       CODE_CLICK_LONG = 3'd3;
`endif
    localparam logic [2:0]       MAX_CNT         = 3'(MAX_CLICKS);
    localparam logic [CNT_W-1:0] TIMER_LAST      = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_nx;
    logic [2:0]       cnt, cnt_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic             emit;
    logic [2:0]       emit_code;
    logic [2:0]       emit_count;

    // Gesture state, click count and gap timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            timer <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            timer <= timer_nx;
            busy  <= (state_nx == COUNTING);
        end
    end

    // Classification; press_long beats press_short, press_short beats timeout
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        timer_nx   = timer;
        emit       = 1'b0;
        emit_code  = 3'd0;
        emit_count = 3'd0;
        case (state)
            IDLE: begin
                if (press_long) begin
                    emit      = 1'b1;
                    emit_code = CODE_LONG;
                end else if (press_short) begin
                    cnt_nx   = 3'd1;
                    timer_nx = '0;
                    state_nx = COUNTING;
                end
            end
            COUNTING: begin
                if (press_long) begin
                    emit       = 1'b1;
`ifdef BUTTON_GESTURE_COMBO_EN
                    emit_code  = CODE_CLICK_LONG;
                    emit_count = cnt;
`else
                    emit_code  = CODE_LONG;
`endif
                    cnt_nx     = 3'd0;
                    timer_nx   = '0;
                    state_nx   = IDLE;
                end else if (press_short) begin
                    if (cnt + 3'd1 == MAX_CNT) begin
                        emit       = 1'b1;
                        emit_code  = CODE_CLICK;
                        emit_count = MAX_CNT;
                        cnt_nx     = 3'd0;
                        state_nx   = IDLE;
                    end else begin
                        cnt_nx = cnt + 3'd1;
                    end
                    timer_nx = '0;
                end else if (timer == TIMER_LAST) begin
                    emit       = 1'b1;
                    emit_code  = CODE_CLICK;
                    emit_count = cnt;
                    cnt_nx     = 3'd0;
                    timer_nx   = '0;
                    state_nx   = IDLE;
                end else begin
                    timer_nx = timer + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
                timer_nx = '0;
            end
        endcase
    end

    // One-entry event buffer; a full buffer drops new events and flags overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid <= 1'b0;
            ev_code  <= 3'd0;
            ev_count <= 3'd0;
            overflow <= 1'b0;
        end else if (emit) begin
            if (!ev_valid || ev_ready) begin
                ev_valid <= 1'b1;
                ev_code  <= emit_code;
                ev_count <= emit_count;
            end else begin
                overflow <= 1'b1;
            end
        end else if (ev_valid && ev_ready) begin
            ev_valid <= 1'b0;
            ev_code  <= 3'd0;
            ev_count <= 3'd0;
        end
    end

endmodule

// File: tb/tb_button_gesture.sv
// Directed bench for button_gesture with GAP_CYCLES=16, MAX_CLICKS=3.
module tb_button_gesture;

    logic       clk = 1'b0;
    logic       rst;
    logic       press_short;
    logic       press_long;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic [2:0] ev_count;
    logic       ev_ready;
    logic       overflow;
    logic       busy;

    int checks = 0;
    int errors = 0;

    button_gesture #(
        .GAP_CYCLES(16),
        .MAX_CLICKS(3),
        .CNT_W     (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .press_short(press_short),
        .press_long (press_long),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .ev_count   (ev_count),
        .ev_ready   (ev_ready),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ps;
        logic       pl;
        logic       rdy;
        logic       v;
        logic [2:0] code;
        logic [2:0] count;
        logic       bsy;
        logic       ovf;
    } vec_t;

    vec_t vecs [19];

    // Apply inputs for one cycle, sample #1 after the edge, drop the pulses
    task automatic step(input logic ps, input logic pl, input logic rdy);
        press_short = ps;
        press_long  = pl;
        ev_ready    = rdy;
        @(posedge clk);
        #1;
        press_short = 1'b0;
        press_long  = 1'b0;
    endtask

    task automatic check(input string name, input logic v, input logic [2:0] code,
                         input logic [2:0] count, input logic bsy, input logic ovf);
        checks++;
        if (ev_valid !== v || ev_code !== code || ev_count !== count ||
            busy !== bsy || overflow !== ovf) begin
            errors++;
            $display("FAIL %s: got v=%b code=%0d count=%0d busy=%b ovf=%b, want v=%b code=%0d count=%0d busy=%b ovf=%b",
                     name, ev_valid, ev_code, ev_count, busy, overflow, v, code, count, bsy, ovf);
        end
    endtask

    initial begin
        logic [2:0] combo_code;
        logic [2:0] combo_count;
`ifdef BUTTON_GESTURE_COMBO_EN
        combo_code  = 3'd3;
        combo_count = 3'd1;
`else
        combo_code  = 3'd2;
        combo_count = 3'd0;
`endif
        //              ps    pl    rdy   v     code  count bsy   ovf
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 3'd3, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1, combo_code, combo_count, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};

        rst = 1'b1;
        press_short = 1'b0;
        press_long  = 1'b0;
        ev_ready    = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single click timing out 16 edges after the press
        step(1'b1, 1'b0, 1'b1);
        check("single_press_busy", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        for (int k = 1; k < 16; k++) begin
            step(1'b0, 1'b0, 1'b1);
            check("single_wait", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        check("single_event", 1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("single_consumed", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

        // Double click, second press 5 cycles after the first
        step(1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 5; k++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 16; k++) begin
            step(1'b0, 1'b0, 1'b1);
            check("double_wait", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        check("double_event", 1'b1, 3'd1, 3'd2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Press landing exactly on the timeout cycle extends the gesture
        step(1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 16; k++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("timeout_press_wins", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        for (int k = 1; k < 16; k++) begin
            step(1'b0, 1'b0, 1'b1);
            check("timeout_press_wait", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        check("timeout_press_event", 1'b1, 3'd1, 3'd2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Table: long in idle, triple click, simultaneous pulses, click then long
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].ps, vecs[i].pl, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].v, vecs[i].code, vecs[i].count,
                  vecs[i].bsy, vecs[i].ovf);
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b1);
            check("no_late_timeout", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        end

        // Back-pressure: second event dropped, first held, overflow sticky
        step(1'b0, 1'b1, 1'b0);
        check("bp_first", 1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
        for (int k = 1; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check("bp_hold", 1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("bp_click_dropped", 1'b1, 3'd2, 3'd0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("bp_overflow", 1'b1, 3'd2, 3'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("bp_consume", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("bp_sticky", 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);

        // Reset mid-gesture discards clicks and clears overflow
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("pre_reset_busy", 1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        check("mid_reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 24; k++) begin
            step(1'b0, 1'b0, 1'b1);
            check("post_reset_quiet", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
